// File: rtl/glip_stream_arbiter_pkg.sv
// rtl/glip_stream_arbiter_pkg.sv - shared types and constants for the GLIP stream arbiter
//
// Purpose: arbiter state encoding, header marker byte and a width helper.
// Ports:   none (package).
package glip_stream_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        BURST  = 2'd2
    } state_t;

    localparam logic [7:0] HDR_MARKER = 8'hA5;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/glip_rr_arbiter.sv
// rtl/glip_rr_arbiter.sv - combinational round-robin channel pick
//
// Purpose: returns the first requesting channel searching upward from last+1 modulo CHANNELS.
// Ports:   req      - per-channel request
//          last     - index of the channel served most recently
//          gnt_idx  - winning channel index (0 when nothing requests)
//          any_req  - at least one request is present
module glip_rr_arbiter
#(
    parameter int CHANNELS = 4
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [2:0]          last,
    output logic [2:0]          gnt_idx,
    output logic                any_req
);

    logic [7:0] req_ext;

    // Widening to 8 lets a 3-bit index select exactly, whatever CHANNELS is.
    assign req_ext = 8'(req);
    assign any_req = |req;

    // Scan from lowest to highest priority so the final hit is the highest-priority requester.
    always_comb begin
        gnt_idx = 3'd0;
        for (int k = CHANNELS; k >= 1; k--) begin
            if (req_ext[3'((int'(last) + k) % CHANNELS)]) begin
                gnt_idx = 3'((int'(last) + k) % CHANNELS);
            end
        end
    end

endmodule

// File: rtl/glip_stream_arbiter.sv
// rtl/glip_stream_arbiter.sv - round-robin burst arbiter feeding the GLIP FIFO output stream
//
// Purpose: grants one of CHANNELS source streams for up to MAX_BURST words at a time,
//          optionally prefixing each grant with a header word {A5, zeros, grant}.
// Config:  define GLIP_STREAM_ARBITER_HEADER_EN to emit the header word per grant.
// Ports:   clk, rst           - clock, synchronous active-high reset
//          in_valid/in_data   - per-channel source streams (channel c at [c*WIDTH +: WIDTH])
//          in_ready           - per-channel accept
//          out_valid/out_data - merged stream towards fifo_out_valid/fifo_out_data
//          out_ready          - from fifo_out_ready
//          grant              - channel currently served
//          busy               - arbiter is not idle
module glip_stream_arbiter
    import glip_stream_arbiter_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int CHANNELS  = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    input  logic                      out_ready,
    output logic [2:0]                grant,
    output logic                      busy
);

    localparam int CW    = clog2(MAX_BURST + 1);
    localparam int EXT_W = 8 * WIDTH;

    state_t                state;
    state_t                state_next;
    logic [2:0]            last_grant;
    logic [2:0]            pick;
    logic                  any_req;
    logic [CW-1:0]         count;
    logic [7:0]            valid_ext;
    logic [7:0][WIDTH-1:0] data_ext;
    logic                  sel_valid;
    logic [WIDTH-1:0]      sel_data;

    glip_rr_arbiter #(
        .CHANNELS (CHANNELS)
    ) u_rr (
        .req     (in_valid),
        .last    (last_grant),
        .gnt_idx (pick),
        .any_req (any_req)
    );

    // Pad to eight channels so the 3-bit grant indexes the source mux exactly.
    assign valid_ext = 8'(in_valid);
    assign data_ext  = EXT_W'(in_data);
    assign sel_valid = valid_ext[grant];
    assign sel_data  = data_ext[grant];

`ifdef GLIP_STREAM_ARBITER_HEADER_EN
    logic [WIDTH-1:0] header_word;

    always_comb begin
        header_word                 = '0;
        header_word[WIDTH-1 -: 8]   = HDR_MARKER;
        header_word[7:0]            = {5'd0, grant};
    end
`endif

    always_comb begin
        state_next = state;
        out_valid  = 1'b0;
        out_data   = '0;
        in_ready   = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
`ifdef GLIP_STREAM_ARBITER_HEADER_EN
                    state_next = HEADER;
`else
                    state_next = BURST;
`endif
                end
            end
`ifdef GLIP_STREAM_ARBITER_HEADER_EN
            HEADER: begin
                out_valid = 1'b1;
                out_data  = header_word;
                if (out_ready) begin
                    state_next = BURST;
                end
            end
`endif
            BURST: begin
                out_valid = sel_valid;
                out_data  = sel_data;
                in_ready  = {{(CHANNELS-1){1'b0}}, out_ready} << grant;
                // A gap on the granted source or the last allowed word closes the burst.
                if (!sel_valid || (out_ready && count == CW'(MAX_BURST - 1))) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Reset kills the handshake in the same cycle so nothing transfers while it is high.
        if (rst) begin
            out_valid = 1'b0;
            in_ready  = '0;
        end
    end

    assign busy = (state != IDLE) && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= 3'd0;
            last_grant <= 3'(CHANNELS - 1);
            count      <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && any_req) begin
                grant <= pick;
            end
            if (state == BURST) begin
                if (state_next == IDLE) begin
                    last_grant <= grant;
                    count      <= '0;
                end else if (sel_valid && out_ready) begin
                    count <= count + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_glip_stream_arbiter.sv
// tb/tb_glip_stream_arbiter.sv - self-checking bench for glip_stream_arbiter
module tb_glip_stream_arbiter;

    localparam int W  = 16;
    localparam int CH = 4;
    localparam int MB = 4;
`ifdef GLIP_STREAM_ARBITER_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [CH-1:0]   in_valid = '0;
    logic [CH*W-1:0] in_data = '0;
    logic [CH-1:0]   in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_ready = 1'b0;
    logic [2:0]      grant;
    logic            busy;

    always #5 clk = ~clk;

    glip_stream_arbiter #(
        .WIDTH     (W),
        .CHANNELS  (CH),
        .MAX_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    int vectors = 0;
    int miscompares = 0;

    // stimulus state
    logic [15:0] src_q[CH][$];
    bit          src_v[CH];
    logic [15:0] cur_d[CH];
    int          gap_pct = 0;
    int          ready_pct = 100;
    bit          ready_toggle = 1'b0;
    bit          ready_phase = 1'b1;
    bit          rst_drv = 1'b1;

    // behavioural model of the arbitration rules
    bit m_active = 1'b0;
    bit m_hdr = 1'b0;
    int m_owner = 0;
    int m_taken = 0;
    int m_last = CH - 1;

    // observations of the DUT for literal checks
    logic [15:0] out_log[$];
    int          seg_grant[$];
    int          seg_words[$];
    int          seg_first_ov[$];
    bit          prev_busy = 1'b0;
    int          busy_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int model_pick(input logic [CH-1:0] req, input int last);
        for (int k = 1; k <= CH; k++) begin
            if (req[(last + k) % CH]) return (last + k) % CH;
        end
        return 0;
    endfunction

    function automatic bit all_empty();
        for (int c = 0; c < CH; c++) begin
            if (src_q[c].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic step();
        logic [CH-1:0] exp_ir;
        logic [CH-1:0] acc;
        logic          exp_ov;
        logic          exp_busy;
        logic [15:0]   exp_od;
        @(posedge clk);
        #2;
        rst = rst_drv;
        if (ready_toggle) begin
            out_ready   = ready_phase;
            ready_phase = ~ready_phase;
        end else begin
            out_ready = ($urandom_range(0, 99) < ready_pct);
        end
        for (int c = 0; c < CH; c++) begin
            if (!src_v[c] && src_q[c].size() > 0 && $urandom_range(0, 99) >= gap_pct) src_v[c] = 1'b1;
            cur_d[c]           = src_v[c] ? src_q[c][0] : 16'($urandom);
            in_valid[c]        = src_v[c];
            in_data[c*W +: W]  = cur_d[c];
        end
        #3;
        exp_ov   = 1'b0;
        exp_od   = '0;
        exp_ir   = '0;
        exp_busy = 1'b0;
        if (!rst && m_active) begin
            exp_busy = 1'b1;
            chk("grant", 32'(grant), 32'(m_owner));
            if (m_hdr) begin
                exp_ov = 1'b1;
                exp_od = 16'hA500 | 16'(m_owner);
            end else begin
                exp_ov = src_v[m_owner];
                exp_od = cur_d[m_owner];
                exp_ir = CH'(out_ready) << m_owner;
            end
        end
        chk("out_valid", 32'(out_valid), 32'(exp_ov));
        chk("in_ready", 32'(in_ready), 32'(exp_ir));
        chk("busy", 32'(busy), 32'(exp_busy));
        if (exp_ov) chk("out_data", 32'(out_data), 32'(exp_od));

        busy_cycles += int'(busy);
        if (busy && !prev_busy) begin
            seg_grant.push_back(int'(grant));
            seg_words.push_back(0);
            seg_first_ov.push_back(int'(out_valid));
        end
        if (out_valid && out_ready) begin
            out_log.push_back(out_data);
            if (seg_words.size() > 0) seg_words[seg_words.size()-1]++;
        end
        prev_busy = busy;

        acc = rst ? '0 : (exp_ir & in_valid);
        for (int c = 0; c < CH; c++) begin
            if (acc[c]) begin
                void'(src_q[c].pop_front());
                src_v[c] = 1'b0;
            end
        end
        if (rst) begin
            m_active = 1'b0;
            m_last   = CH - 1;
            m_taken  = 0;
        end else if (!m_active) begin
            if (|in_valid) begin
                m_owner  = model_pick(in_valid, m_last);
                m_active = 1'b1;
                m_hdr    = (HDR != 0);
                m_taken  = 0;
            end
        end else if (m_hdr) begin
            if (out_ready) m_hdr = 1'b0;
        end else if (!in_valid[m_owner]) begin
            m_active = 1'b0;
            m_last   = m_owner;
        end else if (out_ready) begin
            m_taken++;
            if (m_taken == MB) begin
                m_active = 1'b0;
                m_last   = m_owner;
            end
        end
    endtask

    task automatic reset_dut();
        for (int c = 0; c < CH; c++) begin
            src_q[c].delete();
            src_v[c] = 1'b0;
        end
        gap_pct      = 0;
        ready_pct    = 100;
        ready_toggle = 1'b0;
        rst_drv      = 1'b1;
        step();
        step();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        rst_drv = 1'b0;
        out_log.delete();
        seg_grant.delete();
        seg_words.delete();
        seg_first_ov.delete();
        busy_cycles = 0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (!(all_empty() && !m_active) && n < budget) begin
            step();
            n++;
        end
        chk("drain_timeout", 32'(all_empty() && !m_active), 32'd1);
    endtask

    task automatic wait_segs(input int nseg, input int budget);
        int n;
        n = 0;
        while (seg_grant.size() < nseg && n < budget) begin
            step();
            n++;
        end
        chk("segment_timeout", 32'(seg_grant.size() >= nseg), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5] = '{0, 1, 2, 3, 0};
        int n;
        int hdr_cnt;

        // single channel, three words, then idle
        reset_dut();
        src_q[2].push_back(16'h1111);
        src_q[2].push_back(16'h2222);
        src_q[2].push_back(16'h3333);
        drain(40);
        chk("single_log_size", 32'(out_log.size()), 32'(3 + HDR));
`ifdef GLIP_STREAM_ARBITER_HEADER_EN
        chk("single_header", 32'(out_log[0]), 32'h0000A502);
`endif
        chk("single_w0", 32'(out_log[HDR]), 32'h1111);
        chk("single_w1", 32'(out_log[HDR+1]), 32'h2222);
        chk("single_w2", 32'(out_log[HDR+2]), 32'h3333);
        chk("single_busy_cycles", 32'(busy_cycles), 32'(4 + HDR));

        // every channel saturated
        reset_dut();
        for (int c = 0; c < CH; c++)
            for (int i = 0; i < 30; i++) src_q[c].push_back(16'(c * 16'h1000 + 16'h0100 + i));
        wait_segs(6, 200);
        for (int i = 0; i < 5 && i < seg_grant.size(); i++) begin
            chk("rr_order", 32'(seg_grant[i]), 32'(exp_order[i]));
            chk("rr_words", 32'(seg_words[i]), 32'(MB + HDR));
        end
        chk("rr_first_word", 32'(out_log[0]), (HDR != 0) ? 32'h0000A500 : 32'h00000100);

        // out_ready toggling 1010 on a ch1 burst
        reset_dut();
        ready_toggle = 1'b1;
        ready_phase  = 1'b1;
        for (int i = 1; i <= 4; i++) src_q[1].push_back(16'(16'h1100 + i));
        drain(60);
        ready_toggle = 1'b0;
        chk("toggle_log_size", 32'(out_log.size()), 32'(4 + HDR));
`ifdef GLIP_STREAM_ARBITER_HEADER_EN
        chk("toggle_header", 32'(out_log[0]), 32'h0000A501);
`endif
        for (int i = 0; i < 4 && HDR + i < out_log.size(); i++)
            chk("toggle_word", 32'(out_log[HDR+i]), 32'(16'h1101 + i));

        // reset in the middle of a ch3 burst
        reset_dut();
        for (int i = 1; i <= 6; i++) src_q[3].push_back(16'(16'h3300 + i));
        n = 0;
        while (out_log.size() < 2 + HDR && n < 50) begin
            step();
            n++;
        end
        chk("abort_setup_timeout", 32'(out_log.size() >= 2 + HDR), 32'd1);
        src_q[0].push_back(16'h0301);
        src_q[0].push_back(16'h0302);
        seg_grant.delete();
        seg_words.delete();
        rst_drv = 1'b1;
        step();
        rst_drv = 1'b0;
        step();
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        wait_segs(2, 60);
        chk("abort_next_grant", 32'(seg_grant[0]), 32'd0);
        chk("abort_then_ch3", 32'(seg_grant[1]), 32'd3);
        drain(100);

        // two requesters: ch0 first, ch1 after a full burst
        reset_dut();
        for (int i = 1; i <= 6; i++) begin
            src_q[0].push_back(16'(16'h0100 + i));
            src_q[1].push_back(16'(16'h1100 + i));
        end
        wait_segs(3, 100);
        chk("pair_grant0", 32'(seg_grant[0]), 32'd0);
        chk("pair_grant1", 32'(seg_grant[1]), 32'd1);
        chk("pair_words0", 32'(seg_words[0]), 32'(MB + HDR));
        chk("pair_first_ov", 32'(seg_first_ov[0]), 32'd1);
        chk("pair_first_word", 32'(out_log[0]), (HDR != 0) ? 32'h0000A500 : 32'h00000101);
        hdr_cnt = 0;
        foreach (out_log[i]) if (out_log[i][15:8] == 8'hA5) hdr_cnt++;
        chk("pair_header_count", 32'(hdr_cnt), 32'(HDR * seg_grant.size()));

        // randomized traffic with occasional reset pulses
        reset_dut();
        gap_pct   = 30;
        ready_pct = 70;
        for (int t = 0; t < 3000; t++) begin
            for (int c = 0; c < CH; c++)
                while (src_q[c].size() < 3) src_q[c].push_back(16'($urandom));
            rst_drv = ($urandom_range(0, 99) == 0);
            step();
        end
        rst_drv   = 1'b0;
        gap_pct   = 0;
        ready_pct = 100;
        drain(300);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
